// File: rtl/alu_core_pkg.sv
// Shared ALU definitions: opcode encodings, default data width and FSM state type.
package alu_core_pkg;
  localparam int ALU_DATA_W = 8;
  localparam int FLAG_LEN   = 2;

  localparam logic [3:0] ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] ALU_OP_ADC  = 4'h1;
  localparam logic [3:0] ALU_OP_SUB  = 4'h2;
  localparam logic [3:0] ALU_OP_SBC  = 4'h3;
  localparam logic [3:0] ALU_OP_AND  = 4'h4;
  localparam logic [3:0] ALU_OP_OR   = 4'h5;
  localparam logic [3:0] ALU_OP_XOR  = 4'h6;
  localparam logic [3:0] ALU_OP_NOT  = 4'h7;
  localparam logic [3:0] ALU_OP_SHL  = 4'h8;
  localparam logic [3:0] ALU_OP_SHR  = 4'h9;
  localparam logic [3:0] ALU_OP_ROL  = 4'hA;
  localparam logic [3:0] ALU_OP_CMP  = 4'hB;
  localparam logic [3:0] ALU_OP_MUL  = 4'hC;
  localparam logic [3:0] ALU_OP_INC  = 4'hD;
  localparam logic [3:0] ALU_OP_DEC  = 4'hE;
  localparam logic [3:0] ALU_OP_PASS = 4'hF;

  typedef enum logic {ST_IDLE, ST_MUL} alu_state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial-product add and right shift per step, DATA_W steps.
module alu_mul_seq
  import alu_core_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic [2*DATA_W-1:0]   prod_d_o,
  output logic                  last_o
);
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W:0]     hi_sum;

  // Low half starts as the multiplier and is consumed LSB-first as the product shifts in.
  always_comb begin
    hi_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]};
    if (prod_q[0]) hi_sum = hi_sum + {1'b0, mcand_q};
    prod_d_o = {hi_sum, prod_q[DATA_W-1:1]};
  end

  assign last_o = (cnt_q == CNT_W'(DATA_W-1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= a_i;
      prod_q  <= {{DATA_W{1'b0}}, b_i};
      cnt_q   <= '0;
    end else if (step_i) begin
      prod_q  <= prod_d_o;
      cnt_q   <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/alu_core.sv
// Multi-cycle ALU: single-cycle ops complete on the accepting edge, MUL runs DATA_W steps.
module alu_core
  import alu_core_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic              set_flag_alu,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              fl_zf,
  output logic              fl_cf
);
  localparam int W1 = DATA_W + 1;

  alu_state_e state_q, state_d;
  logic accept, mul_load, mul_step, mul_last;
  logic [2*DATA_W-1:0] prod_d;
  logic [W1-1:0] ext_a, ext_b, ext_c, wide;
  logic [DATA_W-1:0] res_c;
  logic cf_c, zf_c;
  logic done_q, zf_q, cf_q;
  logic [DATA_W-1:0] result_q, result_hi_q;

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .CLK(CLK), .RESET(RESET), .load_i(mul_load), .step_i(mul_step),
    .a_i(a), .b_i(b), .prod_d_o(prod_d), .last_o(mul_last)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && op == ALU_OP_MUL) state_d = ST_MUL;
      ST_MUL:  if (mul_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_MUL);
    accept   = (state_q == ST_IDLE) && start;
    mul_load = accept && (op == ALU_OP_MUL);
    mul_step = (state_q == ST_MUL);
  end

  // Everything is formed at DATA_W+1 bits so the top bit is always the CF value.
  always_comb begin
    ext_a = {1'b0, a};
    ext_b = {1'b0, b};
    ext_c = {{DATA_W{1'b0}}, carry_in};
    wide  = '0;
    case (op)
      ALU_OP_ADD:  wide = ext_a + ext_b;
      ALU_OP_ADC:  wide = ext_a + ext_b + ext_c;
      ALU_OP_SUB,
      ALU_OP_CMP:  wide = ext_a - ext_b;
      ALU_OP_SBC:  wide = ext_a - ext_b - ext_c;
      ALU_OP_AND:  wide = {1'b0, a & b};
      ALU_OP_OR:   wide = {1'b0, a | b};
      ALU_OP_XOR:  wide = {1'b0, a ^ b};
      ALU_OP_NOT:  wide = {1'b0, ~a};
      ALU_OP_SHL:  wide = {a, 1'b0};
      ALU_OP_SHR:  wide = {a[0], 1'b0, a[DATA_W-1:1]};
      ALU_OP_ROL:  wide = {a, carry_in};
      ALU_OP_INC:  wide = ext_a + W1'(1);
      ALU_OP_DEC:  wide = ext_a - W1'(1);
      ALU_OP_PASS: wide = ext_b;
      default:     wide = '0;
    endcase
    res_c = wide[DATA_W-1:0];
    cf_c  = wide[DATA_W];
    zf_c  = (res_c == '0);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      done_q      <= 1'b0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept && op != ALU_OP_MUL) begin
        done_q <= 1'b1;
        zf_q   <= zf_c;
        cf_q   <= cf_c;
        // CMP only updates flags
        if (op != ALU_OP_CMP) begin
          result_q    <= res_c;
          result_hi_q <= '0;
        end
      end else if (mul_step && mul_last) begin
        done_q      <= 1'b1;
        result_q    <= prod_d[DATA_W-1:0];
        result_hi_q <= prod_d[2*DATA_W-1:DATA_W];
        zf_q        <= (prod_d == '0);
        cf_q        <= |prod_d[2*DATA_W-1:DATA_W];
      end
    end
  end

  assign done         = done_q;
  assign set_flag_alu = done_q;
  assign result       = result_q;
  assign result_hi    = result_hi_q;
  assign fl_zf        = zf_q;
  assign fl_cf        = cf_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: reset, single-cycle ops, MUL timing and back-to-back issue.
module tb_alu_core;
  logic       CLK, RESET, start, carry_in;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       busy, done, set_flag_alu, fl_zf, fl_cf;
  logic [7:0] result, result_hi;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  alu_core #(.DATA_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .op(op), .a(a), .b(b),
    .carry_in(carry_in), .busy(busy), .done(done), .set_flag_alu(set_flag_alu),
    .result(result), .result_hi(result_hi), .fl_zf(fl_zf), .fl_cf(fl_cf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // done pulses are counted and set_flag_alu is held against done every cycle
  always @(negedge CLK) begin
    if (done === 1'b1) done_cnt++;
    n_cmp++;
    if (set_flag_alu !== done) begin
      n_err++;
      $display("FAIL set_flag_eq_done got %b want %b t=%0t", set_flag_alu, done, $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Drives one accepted request; returns 1ns after the accepting edge with inputs scrambled.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge CLK);
    start = 1'b1; op = o; a = x; b = y; carry_in = c;
    @(posedge CLK); #1;
    start = 1'b0; a = ~x; b = ~y; carry_in = ~c; op = 4'h0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; start = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00; carry_in = 1'b0;
    #12;
    n_cmp++; if ({busy, done, set_flag_alu, fl_zf, fl_cf} !== 5'b0) begin n_err++; $display("FAIL rst_ctrl got %b want 00000", {busy, done, set_flag_alu, fl_zf, fl_cf}); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL rst_result got %h want 00", result); end
    n_cmp++; if (result_hi !== 8'h00) begin n_err++; $display("FAIL rst_result_hi got %h want 00", result_hi); end
    @(negedge CLK); RESET = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    int d0;
    issue(4'hC, 8'd7, 8'd9, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_start got %b want 1", busy); end
    d0 = done_cnt;
    @(posedge CLK); @(posedge CLK); #3;
    RESET = 1'b0; #1;
    n_cmp++; if ({busy, done, set_flag_alu, fl_zf, fl_cf} !== 5'b0) begin n_err++; $display("FAIL rstmul_ctrl got %b want 00000", {busy, done, set_flag_alu, fl_zf, fl_cf}); end
    n_cmp++; if ({result, result_hi} !== 16'h0000) begin n_err++; $display("FAIL rstmul_data got %h want 0000", {result, result_hi}); end
    @(negedge CLK); RESET = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL rstmul_no_done got %0d want %0d", done_cnt, d0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmul_idle got %b want 0", busy); end
    issue(4'h0, 8'd1, 8'd1, 1'b0);
    n_cmp++; if ({done, result, fl_zf, fl_cf} !== {1'b1, 8'd2, 2'b00}) begin n_err++; $display("FAIL add_after_rst got %b/%h/%b%b want 1/02/00", done, result, fl_zf, fl_cf); end
  endtask

  task automatic test_add_adc();
    issue(4'h0, 8'hFF, 8'h01, 1'b0);
    n_cmp++; if ({done, set_flag_alu} !== 2'b11) begin n_err++; $display("FAIL add_done got %b want 11", {done, set_flag_alu}); end
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'h00, 2'b11}) begin n_err++; $display("FAIL add_ff01 got %h/%b%b want 00/11", result, fl_zf, fl_cf); end
    @(posedge CLK); #1;
    n_cmp++; if ({done, set_flag_alu} !== 2'b00) begin n_err++; $display("FAIL add_done_1cyc got %b want 00", {done, set_flag_alu}); end
    issue(4'h1, 8'h10, 8'h20, 1'b1);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'h31, 2'b00}) begin n_err++; $display("FAIL adc got %h/%b%b want 31/00", result, fl_zf, fl_cf); end
  endtask

  task automatic test_sub_cmp();
    issue(4'h2, 8'h05, 8'h07, 1'b0);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'hFE, 2'b01}) begin n_err++; $display("FAIL sub got %h/%b%b want FE/01", result, fl_zf, fl_cf); end
    issue(4'hB, 8'h42, 8'h42, 1'b0);
    n_cmp++; if ({done, result, fl_zf, fl_cf} !== {1'b1, 8'hFE, 2'b10}) begin n_err++; $display("FAIL cmp got %b/%h/%b%b want 1/FE/10", done, result, fl_zf, fl_cf); end
    issue(4'h3, 8'h05, 8'h05, 1'b1);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'hFF, 2'b01}) begin n_err++; $display("FAIL sbc got %h/%b%b want FF/01", result, fl_zf, fl_cf); end
  endtask

  task automatic test_shift_logic();
    issue(4'h9, 8'h81, 8'h00, 1'b0);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'h40, 2'b01}) begin n_err++; $display("FAIL shr got %h/%b%b want 40/01", result, fl_zf, fl_cf); end
    issue(4'hA, 8'h80, 8'h00, 1'b1);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'h01, 2'b01}) begin n_err++; $display("FAIL rol got %h/%b%b want 01/01", result, fl_zf, fl_cf); end
    issue(4'h6, 8'hAA, 8'hAA, 1'b0);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'h00, 2'b10}) begin n_err++; $display("FAIL xor got %h/%b%b want 00/10", result, fl_zf, fl_cf); end
    issue(4'h8, 8'hC3, 8'h00, 1'b0);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'h86, 2'b01}) begin n_err++; $display("FAIL shl got %h/%b%b want 86/01", result, fl_zf, fl_cf); end
    issue(4'h7, 8'h0F, 8'h00, 1'b0);
    n_cmp++; if ({result, fl_zf, fl_cf} !== {8'hF0, 2'b00}) begin n_err++; $display("FAIL not got %h/%b%b want F0/00", result, fl_zf, fl_cf); end
  endtask

  task automatic test_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] prod,
                          input logic zf, input logic cf, input logic poke);
    int cyc, d0, bad_busy;
    issue(4'hC, x, y, 1'b0);
    d0 = done_cnt; cyc = 0; bad_busy = 0;
    n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL mul_start got %b want 10", {busy, done}); end
    while (done !== 1'b1 && cyc < 20) begin
      start = poke && (cyc == 2); op = 4'h0;
      @(posedge CLK); #1;
      start = 1'b0;
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) bad_busy++;
    end
    n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL mul_latency got %0d want 8", cyc); end
    n_cmp++; if (bad_busy !== 0) begin n_err++; $display("FAIL mul_busy_hold got %0d drops want 0", bad_busy); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mul_busy_end got %b want 0", busy); end
    n_cmp++; if ({result_hi, result, fl_zf, fl_cf} !== {prod, zf, cf}) begin n_err++; $display("FAIL mul_value got %h%h/%b%b want %h/%b%b", result_hi, result, fl_zf, fl_cf, prod, zf, cf); end
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL mul_done_count got %0d want %0d", done_cnt, d0 + 1); end
  endtask

  task automatic test_back_to_back();
    int d0;
    @(negedge CLK);
    d0 = done_cnt;
    start = 1'b1; op = 4'hD; a = 8'hFF;
    @(posedge CLK); #1;
    n_cmp++; if ({done, result, fl_zf, fl_cf} !== {1'b1, 8'h00, 2'b11}) begin n_err++; $display("FAIL b2b_inc got %b/%h/%b%b want 1/00/11", done, result, fl_zf, fl_cf); end
    op = 4'hE; a = 8'h00;
    @(posedge CLK); #1;
    n_cmp++; if ({done, result, fl_zf, fl_cf} !== {1'b1, 8'hFF, 2'b01}) begin n_err++; $display("FAIL b2b_dec got %b/%h/%b%b want 1/FF/01", done, result, fl_zf, fl_cf); end
    op = 4'hF; b = 8'h5A; a = 8'h00;
    @(posedge CLK); #1;
    n_cmp++; if ({done, result, result_hi, fl_zf, fl_cf} !== {1'b1, 8'h5A, 8'h00, 2'b00}) begin n_err++; $display("FAIL b2b_pass got %b/%h/%h/%b%b want 1/5A/00/00", done, result, result_hi, fl_zf, fl_cf); end
    start = 1'b0;
    @(posedge CLK); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop got %b want 0", done); end
    n_cmp++; if (done_cnt !== d0 + 3) begin n_err++; $display("FAIL b2b_done_count got %0d want %0d", done_cnt, d0 + 3); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_add_adc();
    test_sub_cmp();
    test_shift_logic();
    test_mul(8'h10, 8'h10, 16'h0100, 1'b0, 1'b1, 1'b1);
    test_mul(8'h00, 8'h37, 16'h0000, 1'b1, 1'b0, 1'b0);
    test_mul(8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1, 1'b0);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
